// File: rtl/divide_pkg.sv
// divide_pkg: shared types and helpers for the iterative signed divider.
//   state_t   - divider FSM states
//   DIVIDE_W  - operand width the package helpers are sized for
//   CNT_W     - iteration counter width
//   abs_ext() - two's-complement magnitude widened to DIVIDE_W+1 bits
package divide_pkg;

  localparam int unsigned DIVIDE_W = 8;
  localparam int unsigned CNT_W    = $clog2(DIVIDE_W);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } state_t;

  // One extra bit so that |-2^(W-1)| is representable.
  function automatic logic [DIVIDE_W:0] abs_ext(input logic [DIVIDE_W-1:0] x);
    logic [DIVIDE_W:0] xe;
    xe = {x[DIVIDE_W-1], x};
    return x[DIVIDE_W-1] ? (~xe + 1'b1) : xe;
  endfunction

endpackage

// File: rtl/divide_step.sv
// divide_step: one combinational restoring shift-compare-subtract stage.
//   rem      in  [W:0]   partial remainder
//   quo      in  [W-1:0] partial quotient / remaining dividend bits
//   dvs      in  [W:0]   divisor magnitude
//   rem_nxt  out [W:0]   remainder after this stage
//   quo_nxt  out [W-1:0] quotient after this stage (new bit in LSB)
module divide_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W:0]   dvs,
  output logic [W:0]   rem_nxt,
  output logic [W-1:0] quo_nxt
);

  logic [W+1:0] sh;
  logic [W+1:0] diff;
  logic         ge;

  always_comb begin
    sh      = {rem, quo[W-1]};
    diff    = sh - {1'b0, dvs};
    ge      = (sh >= {1'b0, dvs});
    rem_nxt = ge ? (W+1)'(diff) : (W+1)'(sh);
    quo_nxt = {quo[W-2:0], ge};
  end

endmodule

// File: rtl/divide.sv
// divide: iterative signed integer divider, one quotient bit per cycle.
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   s_data   in   [0] dividend, [1] divisor (signed, W bits)
//   s_valid  in   operand pair valid
//   s_ready  out  operands accepted (registered, high only in IDLE)
//   m_data   out  [0] quotient, [1] remainder (signed, W bits)
//   m_valid  out  result valid, held until m_ready
//   m_ready  in   downstream accepts result
// Optional: define DIVIDE_BYPASS_EN to finish divisors 0/+1/-1 without
// iterating.
module divide
  import divide_pkg::*;
#(
  parameter int unsigned W = DIVIDE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0][W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [1:0][W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready
);

  state_t             state, state_nxt;
  logic [W:0]         rem, rem_n, step_rem;
  logic [W-1:0]       quo, quo_n, step_quo;
  logic [W:0]         dvs, dvs_n;
  logic               a_neg, a_neg_n;
  logic               q_neg, q_neg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [1:0][W-1:0]  m_data_n;
  logic               m_valid_n;
  logic [W:0]         abs_a, abs_b;
  logic [W-1:0]       rem_lo;

  assign abs_a  = abs_ext(s_data[0]);
  assign abs_b  = abs_ext(s_data[1]);
  assign rem_lo = rem[W-1:0];

  divide_step #(.W(W)) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  always_comb begin
    state_nxt = state;
    rem_n     = rem;
    quo_n     = quo;
    dvs_n     = dvs;
    a_neg_n   = a_neg;
    q_neg_n   = q_neg;
    cnt_n     = cnt;
    m_data_n  = m_data;
    m_valid_n = m_valid;
    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          rem_n     = '0;
          quo_n     = abs_a[W-1:0];
          dvs_n     = abs_b;
          a_neg_n   = s_data[0][W-1];
          // Zero divisor counts as positive so the all-ones quotient the
          // loop produces is reported as -1 regardless of dividend sign.
          q_neg_n   = (s_data[0][W-1] ^ s_data[1][W-1]) && (s_data[1] != '0);
          cnt_n     = CNT_W'(W - 1);
          state_nxt = BUSY;
`ifdef DIVIDE_BYPASS_EN
          // Preload the magnitudes the loop would have produced; FIX
          // applies the signs exactly as on the iterative path.
          if (s_data[1] == '0) begin
            quo_n     = '1;
            rem_n     = abs_a;
            state_nxt = FIX;
          end else if (s_data[1] == W'(1) || s_data[1] == '1) begin
            quo_n     = abs_a[W-1:0];
            rem_n     = '0;
            state_nxt = FIX;
          end
`endif
        end
      end
      BUSY: begin
        rem_n = step_rem;
        quo_n = step_quo;
        if (cnt == '0) begin
          state_nxt = FIX;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      FIX: begin
        m_data_n[0] = q_neg ? (~quo + 1'b1) : quo;
        m_data_n[1] = a_neg ? (~rem_lo + 1'b1) : rem_lo;
        m_valid_n   = 1'b1;
        state_nxt   = DONE;
      end
      DONE: begin
        if (m_ready) begin
          m_valid_n = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      a_neg   <= 1'b0;
      q_neg   <= 1'b0;
      cnt     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      state   <= state_nxt;
      rem     <= rem_n;
      quo     <= quo_n;
      dvs     <= dvs_n;
      a_neg   <= a_neg_n;
      q_neg   <= q_neg_n;
      cnt     <= cnt_n;
      m_data  <= m_data_n;
      m_valid <= m_valid_n;
      s_ready <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_divide.sv
// tb_divide: directed and randomised checks of the divide block (W=8).
module tb_divide;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][7:0]  s_data;
  logic             s_valid;
  logic             s_ready;
  logic [1:0][7:0]  m_data;
  logic             m_valid;
  logic             m_ready;

  int total = 0;
  int bad   = 0;

  divide #(.W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: truncating division plus zero/overflow rules.
  function automatic logic [15:0] ref_div(input logic [7:0] a, input logic [7:0] b);
    int ai, bi, q, r;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      q = -1;
      r = ai;
    end else if (ai == -128 && bi == -1) begin
      q = -128;
      r = 0;
    end else begin
      q = ai / bi;
      r = ai % bi;
    end
    return {r[7:0], q[7:0]};
  endfunction

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input int stall, input bit poke, input string tag);
    int n;
    int exp_lat;
    exp_lat = 9;
`ifdef DIVIDE_BYPASS_EN
    if (b == 8'h00 || b == 8'h01 || b == 8'hFF) exp_lat = 1;
`endif
    s_data[0] = a;
    s_data[1] = b;
    s_valid   = 1'b1;
    n = 0;
    while (!s_ready && n < 40) begin
      step();
      n++;
    end
    check({tag, "/accept"}, 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "/lat"}, 32'(n), 32'(exp_lat));
    check({tag, "/q"}, 32'(m_data[0]), 32'(eq));
    check({tag, "/r"}, 32'(m_data[1]), 32'(er));
    for (int i = 0; i < stall; i++) begin
      s_valid = poke && (i == 1);
      step();
      check({tag, "/hold_q"}, 32'(m_data[0]), 32'(eq));
      check({tag, "/hold_r"}, 32'(m_data[1]), 32'(er));
      check({tag, "/hold_v"}, 32'(m_valid), 32'd1);
      check({tag, "/hold_srdy"}, 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check({tag, "/drop_v"}, 32'(m_valid), 32'd0);
    check({tag, "/srdy_back"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] res;
    logic [7:0]  ra, rb;
    bit          seen;
    int          n;

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    step();
    step();
    check("rst/s_ready", 32'(s_ready), 32'd0);
    check("rst/m_valid", 32'(m_valid), 32'd0);
    check("rst/m_data", 32'(m_data), 32'd0);
    rst = 1'b0;
    step();
    check("idle/s_ready", 32'(s_ready), 32'd1);

    // Basic and sign combinations.
    do_op(8'd100, 8'd7,   8'h0E, 8'h02, 0, 1'b0, "p_p");
    do_op(8'h9C,  8'd7,   8'hF2, 8'hFE, 0, 1'b0, "n_p");
    do_op(8'd100, 8'hF9,  8'hF2, 8'h02, 0, 1'b0, "p_n");
    do_op(8'h9C,  8'hF9,  8'h0E, 8'hFE, 0, 1'b0, "n_n");
    do_op(8'hF9,  8'd3,   8'hFE, 8'hFF, 0, 1'b0, "m7_3");

    // Boundaries.
    do_op(8'd5,   8'd0,   8'hFF, 8'h05, 0, 1'b0, "div0");
    do_op(8'h80,  8'd0,   8'hFF, 8'h80, 0, 1'b0, "div0_min");
    do_op(8'h80,  8'hFF,  8'h80, 8'h00, 0, 1'b0, "ovf");
    do_op(8'h80,  8'd1,   8'h80, 8'h00, 0, 1'b0, "min_by1");
    do_op(8'd0,   8'd5,   8'h00, 8'h00, 0, 1'b0, "zero");

    // Backpressure with an ignored s_valid pulse in the stall window.
    do_op(8'd100, 8'd7,   8'h0E, 8'h02, 5, 1'b1, "bp");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m_valid) seen = 1'b1;
    end
    check("bp/no_stray", 32'(seen), 32'd0);

    // Reset three cycles into BUSY.
    s_data[0] = 8'd100;
    s_data[1] = 8'd7;
    s_valid   = 1'b1;
    n = 0;
    while (!s_ready && n < 40) begin
      step();
      n++;
    end
    step();
    s_valid = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst/m_valid", 32'(m_valid), 32'd0);
    check("mrst/s_ready_low", 32'(s_ready), 32'd0);
    step();
    check("mrst/s_ready", 32'(s_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m_valid) seen = 1'b1;
    end
    check("mrst/no_result", 32'(seen), 32'd0);
    do_op(8'd10, 8'd3, 8'h03, 8'h01, 0, 1'b0, "after_rst");

    // Random operands with random stalls; bias towards boundary operands.
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 8'h00;
        1: rb = 8'h01;
        2: rb = 8'hFF;
        3: ra = 8'h80;
        default: ;
      endcase
      res = ref_div(ra, rb);
      do_op(ra, rb, res[7:0], res[15:8], int'($urandom_range(0, 3)), 1'b0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
